// File: rtl/fft_digit_reverse_buffer.sv
// fft_digit_reverse_buffer: ping-pong frame buffer that replays each
// N-point frame in base-4 digit-reversed order. Optional macro: FFT_MAG_OUT_EN.
module fft_digit_reverse_buffer #(
    parameter  int WIDTH      = 26,
    parameter  int LOG4_N     = 2,
    localparam int HALF_WIDTH = WIDTH >> 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic [HALF_WIDTH:0]   out_mag
);

    localparam int IW = 2 * LOG4_N;
    localparam int N  = 1 << IW;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        BK_EMPTY,
        BK_FILLING,
        BK_FULL,
        BK_DRAINING
    } bank_state_t;

    logic [WIDTH-1:0] r_bank0 [N];
    logic [WIDTH-1:0] r_bank1 [N];

    bank_state_t r_state     [2];
    bank_state_t w_state_nxt [2];

    logic          r_wb;
    logic          r_rb;
    logic [IW-1:0] r_wi;
    logic [IW-1:0] r_ri;

    logic [1:0]       w_full;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [IW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_word;

    // Swap the base-4 digits end to end.
    function automatic logic [IW-1:0] digrev(input logic [IW-1:0] a);
        logic [IW-1:0] r;
        r = '0;
        for (int d = 0; d < LOG4_N; d++) begin
            r[2*d +: 2] = a[2*(LOG4_N-1-d) +: 2];
        end
        return r;
    endfunction

    assign w_full[0] = (r_state[0] == BK_FULL) || (r_state[0] == BK_DRAINING);
    assign w_full[1] = (r_state[1] == BK_FULL) || (r_state[1] == BK_DRAINING);

    assign in_ready  = !w_full[r_wb];
    assign out_valid = w_full[r_rb];

    assign w_wr_fire = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;
    assign w_wr_last = w_wr_fire && (r_wi == IDX_LAST);
    assign w_rd_last = w_rd_fire && (r_ri == IDX_LAST);

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            unique case (r_state[b])
                BK_EMPTY: begin
                    if (w_wr_fire && (r_wb == 1'(b))) begin
                        w_state_nxt[b] = w_wr_last ? BK_FULL : BK_FILLING;
                    end
                end
                BK_FILLING: begin
                    if (w_wr_last && (r_wb == 1'(b))) begin
                        w_state_nxt[b] = BK_FULL;
                    end
                end
                BK_FULL: begin
                    if (w_rd_fire && (r_rb == 1'(b))) begin
                        w_state_nxt[b] = w_rd_last ? BK_EMPTY : BK_DRAINING;
                    end
                end
                BK_DRAINING: begin
                    if (w_rd_last && (r_rb == 1'(b))) begin
                        w_state_nxt[b] = BK_EMPTY;
                    end
                end
            endcase
        end
    end

    // Bank state registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= BK_EMPTY;
            r_state[1] <= BK_EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // Write pointer: advance per accepted sample, flip bank after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb <= 1'b0;
            r_wi <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wb <= ~r_wb;
                r_wi <= '0;
            end else begin
                r_wi <= r_wi + IDX_ONE;
            end
        end
    end

    // Read pointer: advance per accepted output, flip bank after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb <= 1'b0;
            r_ri <= '0;
        end else if (w_rd_fire) begin
            if (w_rd_last) begin
                r_rb <= ~r_rb;
                r_ri <= '0;
            end else begin
                r_ri <= r_ri + IDX_ONE;
            end
        end
    end

    // Sample storage; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            if (r_wb) begin
                r_bank1[r_wi] <= in_data;
            end else begin
                r_bank0[r_wi] <= in_data;
            end
        end
    end

    // Combinational digit-reversed read from the draining bank.
    always_comb begin
        w_rd_addr = digrev(r_ri);
        w_rd_word = r_rb ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
    end

    assign out_data  = w_rd_word;
    assign out_first = out_valid && (r_ri == '0);
    assign out_last  = out_valid && (r_ri == IDX_LAST);

`ifdef FFT_MAG_OUT_EN
    localparam logic [HALF_WIDTH:0] MAG_ONE = 1;

    logic [HALF_WIDTH:0] w_re_x;
    logic [HALF_WIDTH:0] w_im_x;
    logic [HALF_WIDTH:0] w_abs_re;
    logic [HALF_WIDTH:0] w_abs_im;

    // |re|+|im| on one extra bit, so the most negative input needs no clamp.
    always_comb begin
        w_re_x   = {w_rd_word[HALF_WIDTH + HALF_WIDTH - 1],
                    w_rd_word[HALF_WIDTH +: HALF_WIDTH]};
        w_im_x   = {w_rd_word[HALF_WIDTH - 1],
                    w_rd_word[0 +: HALF_WIDTH]};
        w_abs_re = w_re_x[HALF_WIDTH] ? (~w_re_x) + MAG_ONE : w_re_x;
        w_abs_im = w_im_x[HALF_WIDTH] ? (~w_im_x) + MAG_ONE : w_im_x;
        out_mag  = out_valid ? (w_abs_re + w_abs_im) : '0;
    end
`else
    assign out_mag = '0;
`endif

endmodule

// File: tb/tb_fft_digit_reverse_buffer.sv
// tb_fft_digit_reverse_buffer: directed checks of reorder, throughput,
// backpressure, magnitude output and asynchronous reset.
module tb_fft_digit_reverse_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic [13:0] out_mag;

    int checks = 0;
    int errors = 0;

    int tbl [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    fft_digit_reverse_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .out_mag   (out_mag)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] pack(input int re, input int im);
        logic [12:0] r;
        logic [12:0] i;
        r = re[12:0];
        i = im[12:0];
        return {r, i};
    endfunction

    function automatic int get_re(input logic [25:0] d);
        logic signed [12:0] r;
        r = d[25:13];
        return int'(r);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_first !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_markers: got %b%b expected 00", out_first, out_last);
        end
        checks++;
        if (out_mag !== 14'd0) begin
            errors++;
            $display("FAIL rst_mag: got %0d expected 0", out_mag);
        end
        step;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_digit_reversal;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = pack(i, 0);
            if (i == 15) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL dr_valid_early: got %b expected 0", out_valid);
                end
            end
            step;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dr_valid_rise: got %b expected 1", out_valid);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (get_re(out_data) !== tbl[k] || out_data[12:0] !== 13'd0) begin
                errors++;
                $display("FAIL dr_data[%0d]: got re %0d expected %0d", k, get_re(out_data), tbl[k]);
            end
            checks++;
            if (out_first !== (k == 0) || out_last !== (k == 15)) begin
                errors++;
                $display("FAIL dr_markers[%0d]: got %b%b expected %b%b", k, out_first, out_last, (k == 0), (k == 15));
            end
            step;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dr_valid_fall: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int exp;
        out_ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            in_valid = (c < 48);
            in_data = pack(c, 0);
            if (c < 48) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready);
                end
            end
            checks++;
            if (out_valid !== (c >= 16)) begin
                errors++;
                $display("FAIL b2b_out_valid[%0d]: got %b expected %b", c, out_valid, (c >= 16));
            end
            if (c >= 16) begin
                exp = ((c - 16) / 16) * 16 + tbl[(c - 16) % 16];
                checks++;
                if (get_re(out_data) !== exp) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got re %0d expected %0d", c, get_re(out_data), exp);
                end
            end
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int c = 0; c < 32; c++) begin
            in_valid = 1'b1;
            in_data = pack(32 + c, 0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill_ready[%0d]: got %b expected 1", c, in_ready);
            end
            step;
        end
        in_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_full_ready[%0d]: got %b expected 0", h, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || get_re(out_data) !== 32 || out_first !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v%b re %0d f%b expected v1 re 32 f1", h, out_valid, get_re(out_data), out_first);
            end
            step;
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_one: got %b expected 0", in_ready);
        end
        checks++;
        if (get_re(out_data) !== 36 || out_first !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_beat: got re %0d f%b expected re 36 f0", get_re(out_data), out_first);
        end
        step;
        out_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            checks++;
            if (get_re(out_data) !== 32 + tbl[k]) begin
                errors++;
                $display("FAIL bp_f0_data[%0d]: got re %0d expected %0d", k, get_re(out_data), 32 + tbl[k]);
            end
            if (k == 15) begin
                checks++;
                if (out_last !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_f0_last: got %b expected 1", out_last);
                end
            end
            step;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_freed: got %b expected 1", in_ready);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_valid !== 1'b1 || get_re(out_data) !== 48 + tbl[k]) begin
                errors++;
                $display("FAIL bp_f1_data[%0d]: got v%b re %0d expected v1 re %0d", k, out_valid, get_re(out_data), 48 + tbl[k]);
            end
            step;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_magnitude;
        int m0;
        int m1;
        int m2;
`ifdef FFT_MAG_OUT_EN
        m0 = 8192;
        m1 = 250;
        m2 = 8;
`else
        m0 = 0;
        m1 = 0;
        m2 = 0;
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            case (i)
                0: in_data = pack(-4096, -4096);
                1: in_data = pack(100, -150);
                2: in_data = pack(-3, 5);
                default: in_data = pack(0, 0);
            endcase
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                checks++;
                if (get_re(out_data) !== -4096) begin
                    errors++;
                    $display("FAIL mag_re0: got %0d expected -4096", get_re(out_data));
                end
                checks++;
                if (out_mag !== 14'(m0)) begin
                    errors++;
                    $display("FAIL mag_neg_max: got %0d expected %0d", out_mag, m0);
                end
            end
            if (k == 4) begin
                checks++;
                if (out_mag !== 14'(m1)) begin
                    errors++;
                    $display("FAIL mag_mixed: got %0d expected %0d", out_mag, m1);
                end
            end
            if (k == 8) begin
                checks++;
                if (out_mag !== 14'(m2)) begin
                    errors++;
                    $display("FAIL mag_small: got %0d expected %0d", out_mag, m2);
                end
            end
            step;
        end
        out_ready = 1'b0;
        checks++;
        if (out_mag !== 14'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mag_idle: got mag %0d v%b expected 0 v0", out_mag, out_valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        out_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1;
            in_data = pack(200 + i, 0);
            step;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmf_pre_valid: got %b expected 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_first !== 1'b0) begin
            errors++;
            $display("FAIL rmf_async_valid: got v%b f%b expected 00", out_valid, out_first);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmf_async_ready: got %b expected 1", in_ready);
        end
        step;
        rst = 1'b0;
        step;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = pack(16 + i, 0);
            if (i == 15) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rmf_valid_early: got %b expected 0", out_valid);
                end
            end
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_valid !== 1'b1 || get_re(out_data) !== 16 + tbl[k]) begin
                errors++;
                $display("FAIL rmf_data[%0d]: got v%b re %0d expected v1 re %0d", k, out_valid, get_re(out_data), 16 + tbl[k]);
            end
            step;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmf_drained: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_digit_reversal;
        test_back_to_back;
        test_backpressure;
        test_magnitude;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_digit_reverse_buffer.md
# fft_digit_reverse_buffer

Ping-pong reorder buffer for the radix-4 FFT datapath. Accepts one packed complex sample per cycle, in the natural order the butterfly stages produce them, and replays each N-point frame in base-4 digit-reversed order. This restores the output bins to natural order for the visualizer back end. It sits downstream of the final `butterfly_4` stage as the read side of its output stream, and uses the same packed complex format: real in the upper half, imaginary in the lower half, both two's complement.

## Interface
- `WIDTH`, default 26: packed complex sample width; `HALF_WIDTH = WIDTH >> 1` per component.
- `LOG4_N`, default 2: base-4 digits per index; frame length `N = 4**LOG4_N` (16 at default).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_data`, input, WIDTH: packed complex sample in natural order.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: buffer accepts `in_data`; reset value 1.
- `out_data`, output, WIDTH: reordered sample; reset value is don't-care, qualified only by `out_valid`.
- `out_valid`, output, 1: `out_data` is valid; reset value 0.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `out_first`, output, 1: current output is bin 0 of a frame; reset value 0.
- `out_last`, output, 1: current output is bin N-1 of a frame; reset value 0.
- `out_mag`, output, HALF_WIDTH+1: unsigned `|re|+|im|` of `out_data`; reset value 0.

## Operation
- **Storage:** two banks of N × WIDTH registers, bank 0 and bank 1. Each bank has a `full` flag, and both flags reset to 0.
- **Write side:**
  - State is a write bank pointer `wb` and a write index `wi` (0..N-1), both reset to 0.
  - `in_ready = !full[wb]`.
  - On each accepted sample (`in_valid && in_ready`), write to `bank[wb][wi]` and increment `wi`.
  - When the sample at `wi == N-1` is accepted: set `full[wb]`, toggle `wb`, and wrap `wi` to 0.
- **Read side:**
  - State is a read bank pointer `rb` and a read index `ri` (0..N-1), both reset to 0.
  - `out_valid = full[rb]`.
  - `out_data = bank[rb][digrev(ri)]`. `digrev` reverses the order of the LOG4_N base-4 digits, i.e. swaps 2-bit fields end to end.
  - On each accepted output (`out_valid && out_ready`), increment `ri`.
  - When the output at `ri == N-1` is accepted: clear `full[rb]`, toggle `rb`, and wrap `ri` to 0.
- **Frame markers:** `out_first = out_valid && ri == 0`; `out_last = out_valid && ri == N-1`.
- **Per-bank states:** each bank cycles EMPTY → FILLING (`wb` points at it, `wi > 0`) → FULL → DRAINING (`rb` points at it, `ri > 0`) → EMPTY.
- **Boundaries:**
  - *Write side blocked:* writer holds while the target bank is still FULL or DRAINING; `in_ready` stays 0 until the cycle after that bank's last read.
  - *Read side empty:* reader holds while its bank is not full; `out_valid` stays 0.
  - *Simultaneous last write and last read to opposite banks:* both complete in the same cycle with no loss.
  - *Same-bank handover:* set and clear never coincide on the same bank, because the pointers always alternate.
- **Reset mid-frame:**
  - All flags, pointers and indices clear; the partial frame is discarded.
  - Bank contents are not cleared.
  - `in_ready` is 1 and `out_valid` is 0 immediately, asynchronously.

## Timing
- **Latency:** `out_valid` rises in the cycle after the frame's last input is accepted. Bin 0 is available then, because `out_data` is combinational from the register array.
- **Throughput:** sustains one sample per cycle in and out continuously. Frame k+1 fills one bank while frame k drains the other. The first write of frame k+2 is accepted in the cycle after the last read of frame k.
- `out_data`, `out_first`, `out_last` and `out_mag` are held stable while `out_valid && !out_ready`.

## Configuration
- **`FFT_MAG_OUT_EN` defined:**
  - `out_mag = |re| + |im|` of `out_data`, computed combinationally.
  - Each absolute value is zero-extended to HALF_WIDTH+1 bits before the add.
  - The most negative value (`-2**(HALF_WIDTH-1)`) maps to `2**(HALF_WIDTH-1)`; no saturation is needed.
- **`FFT_MAG_OUT_EN` not defined:** `out_mag` is tied to 0 and no magnitude logic is built. All other behaviour is identical.

## Test plan
- **Digit reversal:** stream 16 samples with re = index, im = 0, with `out_ready` held 1. Required:
  - `out_valid` rises one cycle after the 16th accept.
  - Output re sequence is 0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15.
  - `out_first` is high on the first beat and `out_last` on the 16th.
- **Back-to-back frames:** three frames streamed continuously with `in_valid = out_ready = 1`. Required: `in_ready` never drops and `out_valid` stays high for 48 consecutive cycles, with each frame correctly reordered.
- **Backpressure:** `out_ready = 0` while two frames are written. Required:
  - `in_ready` is 0 after the 32nd accept.
  - After 1 read accept, `in_ready` remains 0.
  - After 16 read accepts, `in_ready` is 1 the next cycle.
- **Magnitude (macro defined):** samples re = -4096, im = -4096 and re = 100, im = -150. Required: `out_mag` = 8192 and 250 respectively. With the macro undefined, `out_mag` is 0.
- **Reset mid-frame:** assert `rst` after 7 accepts, deassert, then write a full frame with re = 16 + index. Required: `out_valid` is 0 immediately on `rst`, and the output frame carries only the new values (re = 16, 20, 24, 28, 17, …).
